// File: rtl/lsu_mem_initiator_if.sv
// Bundles the core request/response handshakes and the byte-enabled memory port
// of the load/store initiator.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_err_code;

  logic [3:0]  mem_w_enb;
  logic [3:0]  mem_r_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  // The initiator itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_r_data,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_err_code,
    output mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );

  // The core and the memory, seen together from the other side.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_r_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_err_code,
    input  mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: legality check, one-cycle memory
// access, load-data extension and a registered response.
module lsu_mem_initiator #(
  parameter int ADDR_BITS   = 10,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                clk,
  input  logic                rst,
  lsu_mem_initiator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        funct3_illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [2:0]  size_m1;
  logic [32:0] last_byte;
  logic [1:0]  check_code;
  logic [3:0]  enb_pattern;
  logic [31:0] load_data;

  // Legality of the request currently on the bus; the 33-bit sum keeps
  // addresses near the top of the 32-bit space from wrapping into range.
  always_comb begin
    funct3_illegal = 1'b0;
    misaligned     = 1'b0;
    size_m1        = 3'd3;
    if (bus.req_we) begin
      funct3_illegal = (bus.req_funct3 >= 3'b011);
    end else begin
      funct3_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                       (bus.req_funct3 == 3'b111);
    end
    if (ALIGN_CHECK != 0) begin
      misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end
    case (bus.req_funct3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
    last_byte    = {1'b0, bus.req_addr} + {30'd0, size_m1};
    out_of_range = (last_byte >> ADDR_BITS) != 33'd0;
    if (funct3_illegal) begin
      check_code = 2'b10;
    end else if (misaligned) begin
      check_code = 2'b01;
    end else if (out_of_range) begin
      check_code = 2'b11;
    end else begin
      check_code = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = (check_code == 2'b00) ? ACCESS : RESP;
        end
      end
      ACCESS:  state_d = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   enb_pattern = 4'b0001;
      2'b01:   enb_pattern = 4'b0011;
      default: enb_pattern = 4'b1111;
    endcase
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.mem_w_enb  = 4'b0000;
    bus.mem_r_enb  = 4'b0000;
    // rst gates the enables combinationally so a reset landing in ACCESS never writes.
    if ((state_q == ACCESS) && !rst) begin
      if (we_q) begin
        bus.mem_w_enb = enb_pattern;
      end else begin
        bus.mem_r_enb = enb_pattern;
      end
    end
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{bus.mem_r_data[7]}}, bus.mem_r_data[7:0]};
      3'b100:  load_data = {24'd0, bus.mem_r_data[7:0]};
      3'b001:  load_data = {{16{bus.mem_r_data[15]}}, bus.mem_r_data[15:0]};
      3'b101:  load_data = {16'd0, bus.mem_r_data[15:0]};
      default: load_data = bus.mem_r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q       <= bus.req_we;
            funct3_q   <= bus.req_funct3;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            rdata_q    <= 32'd0;
            err_q      <= (check_code != 2'b00);
            err_code_q <= check_code;
          end
        end
        ACCESS: begin
          rdata_q <= we_q ? 32'd0 : load_data;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_w_data    = wdata_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_err      = err_q;
  assign bus.resp_err_code = err_code_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: one DUT with alignment checking against a
// byte memory model, and one without alignment checking against a fixed pattern.
module tb_lsu_mem_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus; sel picks which DUT sees req_valid and whose outputs are observed.
  bit          sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b1;

  lsu_mem_initiator_if ifa ();
  lsu_mem_initiator_if ifb ();

  lsu_mem_initiator #(.ADDR_BITS(10), .ALIGN_CHECK(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  lsu_mem_initiator #(.ADDR_BITS(10), .ALIGN_CHECK(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.req_valid  = req_valid & ~sel;
  assign ifb.req_valid  = req_valid & sel;
  assign ifa.req_we     = req_we;
  assign ifb.req_we     = req_we;
  assign ifa.req_funct3 = req_funct3;
  assign ifb.req_funct3 = req_funct3;
  assign ifa.req_addr   = req_addr;
  assign ifb.req_addr   = req_addr;
  assign ifa.req_wdata  = req_wdata;
  assign ifb.req_wdata  = req_wdata;
  assign ifa.resp_ready = resp_ready;
  assign ifb.resp_ready = resp_ready;

  // DUT A memory: 1 KiB byte array, data at the base address sits in lane 0.
  bit   [7:0]  mem_a [0:1023];
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata_a[8*i +: 8] = mem_a[10'(ifa.mem_addr[9:0] + i)];
      rdata_b[8*i +: 8] = 8'(ifb.mem_addr + i) ^ 8'hA5;
    end
  end
  assign ifa.mem_r_data = rdata_a;
  assign ifb.mem_r_data = rdata_b;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ifa.mem_w_enb[i]) mem_a[10'(ifa.mem_addr[9:0] + i)] <= ifa.mem_w_data[8*i +: 8];
    end
  end

  wire         o_req_ready  = sel ? ifb.req_ready     : ifa.req_ready;
  wire         o_resp_valid = sel ? ifb.resp_valid    : ifa.resp_valid;
  wire  [31:0] o_rdata      = sel ? ifb.resp_rdata    : ifa.resp_rdata;
  wire         o_err        = sel ? ifb.resp_err      : ifa.resp_err;
  wire  [1:0]  o_code       = sel ? ifb.resp_err_code : ifa.resp_err_code;
  wire  [3:0]  o_wen        = sel ? ifb.mem_w_enb     : ifa.mem_w_enb;
  wire  [3:0]  o_ren        = sel ? ifb.mem_r_enb     : ifa.mem_r_enb;
  wire  [31:0] o_maddr      = sel ? ifb.mem_addr      : ifa.mem_addr;
  wire  [31:0] o_mwdata     = sel ? ifb.mem_w_data    : ifa.mem_w_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one request starting at a negedge and ends at a negedge back in IDLE.
  // hold = cycles resp_ready is kept low once the response is visible.
  task automatic do_req(input bit s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic [3:0] exp_wen, input logic [3:0] exp_ren,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_code);
    bit          got = 1'b0;
    int          lat = 0;
    int          en_cycles = 0;
    logic [3:0]  wseen = 4'd0;
    logic [3:0]  rseen = 4'd0;
    logic [31:0] cap_rdata = 32'd0;
    logic        cap_err = 1'b0;
    logic [1:0]  cap_code = 2'b00;
    sel = s;
    chk("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mem_addr", o_maddr, addr);
    chk("mem_w_data", o_mwdata, wdata);
    for (int c = 1; c <= 4 && !got; c++) begin
      if (c > 1) @(negedge clk);
      wseen = wseen | o_wen;
      rseen = rseen | o_ren;
      if ((o_wen | o_ren) != 4'd0) en_cycles++;
      if (o_resp_valid) begin
        got = 1'b1; lat = c;
        cap_rdata = o_rdata; cap_err = o_err; cap_code = o_code;
      end
    end
    chk("resp_seen", {31'd0, got}, 32'd1);
    chk("latency", lat, (exp_code != 2'b00) ? 32'd1 : 32'd2);
    chk("w_enb", {28'd0, wseen}, {28'd0, exp_wen});
    chk("r_enb", {28'd0, rseen}, {28'd0, exp_ren});
    chk("enb_cycles", en_cycles, ((exp_wen | exp_ren) != 4'd0) ? 32'd1 : 32'd0);
    chk("rdata", cap_rdata, exp_rdata);
    chk("err", {31'd0, cap_err}, {31'd0, (exp_code != 2'b00)});
    chk("err_code", {30'd0, cap_code}, {30'd0, exp_code});
    for (int h = 0; h < hold; h++) begin
      // A request offered while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3FE;
      @(negedge clk);
      chk("hold_valid", {31'd0, o_resp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
      chk("hold_rdata", o_rdata, exp_rdata);
      chk("hold_code", {30'd0, o_code}, {30'd0, exp_code});
      chk("hold_mem_addr", o_maddr, addr);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_drop", {31'd0, o_resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, o_req_ready}, 32'd1);
    $display("req sel=%0d we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d code=%0d lat=%0d wen=%b ren=%b",
             s, we, f3, addr, wdata, cap_rdata, cap_err, cap_code, lat, wseen, rseen);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_w_enb", {28'd0, ifa.mem_w_enb}, 32'd0);
    chk("rst_r_enb", {28'd0, ifa.mem_r_enb}, 32'd0);
    chk("rst_resp_valid", {31'd0, ifa.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, ifa.req_ready}, 32'd1);
    chk("rst_rdata", ifa.resp_rdata, 32'd0);
    chk("rst_code", {30'd0, ifa.resp_err_code}, 32'd0);
    chk("rst_mem_addr", ifa.mem_addr, 32'd0);

    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 4'hF, 4'h0, 32'h0, 2'b00);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, 4'h0, 4'hF, 32'hDEADBEEF, 2'b00);
    do_req(0, 1'b1, 3'b000, 32'h21, 32'h80, 0, 4'h1, 4'h0, 32'h0, 2'b00);
    do_req(0, 1'b0, 3'b000, 32'h21, 32'h0, 0, 4'h0, 4'h1, 32'hFFFFFF80, 2'b00);
    do_req(0, 1'b0, 3'b100, 32'h21, 32'h0, 0, 4'h0, 4'h1, 32'h00000080, 2'b00);
    do_req(0, 1'b1, 3'b001, 32'h30, 32'h8001, 0, 4'h3, 4'h0, 32'h0, 2'b00);
    do_req(0, 1'b0, 3'b001, 32'h30, 32'h0, 0, 4'h0, 4'h3, 32'hFFFF8001, 2'b00);
    do_req(0, 1'b0, 3'b101, 32'h30, 32'h0, 0, 4'h0, 4'h3, 32'h00008001, 2'b00);
    do_req(0, 1'b0, 3'b010, 32'h2, 32'h0, 0, 4'h0, 4'h0, 32'h0, 2'b01);
    do_req(1, 1'b0, 3'b010, 32'h2, 32'h0, 0, 4'h0, 4'hF, 32'hA0A1A6A7, 2'b00);
    do_req(0, 1'b0, 3'b011, 32'h40, 32'h0, 0, 4'h0, 4'h0, 32'h0, 2'b10);
    do_req(0, 1'b1, 3'b100, 32'h40, 32'h55, 0, 4'h0, 4'h0, 32'h0, 2'b10);
    do_req(0, 1'b0, 3'b010, 32'h3FE, 32'h0, 0, 4'h0, 4'h0, 32'h0, 2'b01);
    do_req(1, 1'b0, 3'b010, 32'h3FE, 32'h0, 0, 4'h0, 4'h0, 32'h0, 2'b11);
    do_req(0, 1'b0, 3'b010, 32'h400, 32'h0, 0, 4'h0, 4'h0, 32'h0, 2'b11);
    do_req(0, 1'b0, 3'b010, 32'h3FC, 32'h0, 0, 4'h0, 4'hF, 32'h0, 2'b00);
    do_req(0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h12345678, 0, 4'h0, 4'h0, 32'h0, 2'b11);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 5, 4'h0, 4'hF, 32'hDEADBEEF, 2'b00);

    // Reset during the ACCESS cycle of a store: no write, back to IDLE with zeroed state.
    sel = 1'b0;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("access_w_enb", {28'd0, ifa.mem_w_enb}, 32'hF);
    rst = 1'b1;
    #1;
    chk("rst_access_w_enb", {28'd0, ifa.mem_w_enb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_valid", {31'd0, ifa.resp_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, ifa.req_ready}, 32'd1);
    chk("post_rst_rdata", ifa.resp_rdata, 32'd0);
    chk("post_rst_err", {31'd0, ifa.resp_err}, 32'd0);
    chk("post_rst_mem_addr", ifa.mem_addr, 32'd0);
    chk("post_rst_mem_w_data", ifa.mem_w_data, 32'd0);
    @(negedge clk);
    chk("post_rst_no_resp", {31'd0, ifa.resp_valid}, 32'd0);
    do_req(0, 1'b0, 3'b010, 32'h50, 32'h0, 0, 4'h0, 4'hF, 32'h0, 2'b00);

    // Reset while a response is pending discards it.
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    resp_ready = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("resp_pending", {31'd0, ifa.resp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp_discard", {31'd0, ifa.resp_valid}, 32'd0);
    @(negedge clk);
    chk("rst_resp_idle", {31'd0, ifa.req_ready}, 32'd1);
    chk("rst_resp_no_pulse", {31'd0, ifa.resp_valid}, 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that sits between the core's execute stage and the byte-enabled data memory.
- Accepts one load or store request at a time over a valid/ready handshake.
- Checks the request for legality, then drives the memory's byte-enable, address and write-data port for exactly one cycle.
- Sign- or zero-extends load data and returns a registered response over a second valid/ready handshake.

Parameters:
- ADDR_BITS, 10, byte-address width of the attached memory; the memory holds 2**ADDR_BITS bytes.
- ALIGN_CHECK, 1, when 1, misaligned halfword/word accesses are rejected; when 0, they are passed to memory unchanged.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response available
- resp_ready  input  1  core accepts the response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  request was rejected
- resp_err_code  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 out of range
- mem_w_enb  output  4  memory byte write enables
- mem_r_enb  output  4  memory byte read enables
- mem_addr  output  32  memory base byte address
- mem_w_data  output  32  memory write data
- mem_r_data  input  32  memory read data (combinational, same cycle)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset state:
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, resp_err_code=00.
  - Latched request registers = 0.
  - mem_w_enb = mem_r_enb = 0000, including during any cycle in which rst=1.
- States:
  - IDLE: req_ready=1. On req_valid=1, latch we, funct3, addr and wdata, and evaluate legality. A legal request goes to ACCESS; an illegal one goes to RESP with the error set.
  - ACCESS (exactly 1 cycle):
    - mem_addr = latched addr; mem_w_data = latched wdata.
    - Enable pattern: 0001 for B/BU, 0011 for H/HU, 1111 for W. It drives mem_w_enb if we=1, otherwise mem_r_enb.
    - At the closing edge: register formatted mem_r_data into resp_rdata (stores give 0), then go to RESP.
  - RESP: resp_valid=1; hold resp_rdata, resp_err and resp_err_code stable until resp_ready=1. On that edge, clear resp_valid and go to IDLE.
- req_ready is 0 in ACCESS and RESP. Requests presented there are ignored and not latched.
- Latency and throughput:
  - Accept edge is at cycle 0, ACCESS is cycle 1, resp_valid rises at cycle 2.
  - Minimum 3 cycles per request when resp_ready is held at 1.
- Outside ACCESS: both enable buses are 0000. mem_addr and mem_w_data keep driving the latched values.
- Load formatting:
  - LB: sign-extend bit 7.
  - LBU: zero-extend byte.
  - LH: sign-extend bit 15.
  - LHU: zero-extend halfword.
  - LW: pass through.
- Legality checks, in priority order:
  1. Illegal funct3 (code 10): loads with 011, 110 or 111; stores with funct3 >= 011.
  2. Misaligned (code 01), only when ALIGN_CHECK=1: H/HU with addr[0]=1, W with addr[1:0]!=00.
  3. Out of range (code 11): addr + size - 1 >= 2**ADDR_BITS, computed in 33 bits so that addr near 0xFFFFFFFF cannot wrap.
- Any error: no memory enable is ever asserted, resp_rdata=0, and the response still uses the normal RESP handshake.
- Reset mid-operation:
  - Reset in ACCESS: enables are forced to 0, so no write occurs; the transaction is dropped.
  - Reset in RESP: the pending response is discarded with no resp_valid pulse.
- A new request is only sampled in IDLE, so a response and a new accept never coincide.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10: mem_w_enb=1111 for one cycle; resp_rdata=0xDEADBEEF two cycles after accept; resp_err=0.
- SB 0x21 data 0x00000080, then LB 0x21 and LBU 0x21: mem_w_enb=0001; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0x30 data 0x00008001, then LH and LHU 0x30: LH returns 0xFFFF8001, LHU returns 0x00008001, mem_r_enb=0011.
- LW 0x0000_0002 with ALIGN_CHECK=1: resp_err=1, code 01, no enable asserted. Repeat with ALIGN_CHECK=0: access proceeds with mem_r_enb=1111.
- Illegal and out of range:
  - Load funct3=011: code 10.
  - LW 0x3FE with ADDR_BITS=10: code 11.
  - SW 0xFFFFFFFC: code 11, no wrap and no write.
- Handshake and reset:
  - Hold resp_ready=0 for 5 cycles: response stays stable and req_ready stays 0. Release: resp_valid drops next edge and req_ready returns to 1.
  - Assert rst during the ACCESS of an SW: memory is unchanged and the unit is in IDLE with outputs zero.
